// File: rtl/annunciator_pkg.sv
// rtl/annunciator_pkg.sv - shared FSM states, ASCII constants and nibble renderer for the status annunciator
package annunciator_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, OUT} ann_state_t;

  localparam logic [7:0] END_MARK = 8'h00;
  localparam logic [7:0] ASCII_0  = "0";
  localparam logic [7:0] ASCII_A  = "A";

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] v);
    if (v < 4'd10) return ASCII_0 + {4'd0, v};
    else           return ASCII_A + {4'd0, v} - 8'd10;
  endfunction

endpackage

// File: rtl/ann_char_mux.sv
// rtl/ann_char_mux.sv - picks flag, hex, optional frame-count or template character for a template address
// Optional frame-count digits under STATUS_ANNUNCIATOR_FRAME_COUNT_EN.
module ann_char_mux
  import annunciator_pkg::*;
#(
  parameter int                          NUM_FLAGS  = 8,
  parameter int                          ADDR_W     = 10,
  parameter logic [NUM_FLAGS*ADDR_W-1:0] FLAG_POS   = {8{10'd0}},
  parameter int                          HEX_DIGITS = 2,
  parameter logic [ADDR_W-1:0]           HEX_POS    = 10'd199,
  parameter logic [7:0]                  ON_CHAR    = "1",
  parameter logic [7:0]                  OFF_CHAR   = "0"
`ifdef STATUS_ANNUNCIATOR_FRAME_COUNT_EN
  , parameter logic [ADDR_W-1:0]         FRAME_POS  = 10'd230
`endif
) (
  input  logic [ADDR_W-1:0]       ptr,
  input  logic [NUM_FLAGS-1:0]    snap_flags,
  input  logic [4*HEX_DIGITS-1:0] snap_hex,
`ifdef STATUS_ANNUNCIATOR_FRAME_COUNT_EN
  input  logic [15:0]             snap_cnt,
`endif
  input  logic [7:0]              rom_byte,
  output logic [7:0]              ch
);

  // Later assignments override earlier ones, so the lowest-priority source goes first.
  always_comb begin
    ch = rom_byte;
`ifdef STATUS_ANNUNCIATOR_FRAME_COUNT_EN
    for (int d = 0; d < 4; d++)
      if (ptr == ADDR_W'(FRAME_POS + d))
        ch = nibble_to_ascii(snap_cnt[4*(3-d) +: 4]);
`endif
    for (int d = 0; d < HEX_DIGITS; d++)
      if (ptr == ADDR_W'(HEX_POS + d))
        ch = nibble_to_ascii(snap_hex[4*(HEX_DIGITS-1-d) +: 4]);
    for (int i = NUM_FLAGS - 1; i >= 0; i--)
      if (ptr == FLAG_POS[i*ADDR_W +: ADDR_W])
        ch = snap_flags[i] ? ON_CHAR : OFF_CHAR;
  end

endmodule

// File: rtl/status_annunciator.sv
// rtl/status_annunciator.sv - streams a template status screen with live indicator substitution
// Optional 16-bit frame counter and frame_cnt port under STATUS_ANNUNCIATOR_FRAME_COUNT_EN.
module status_annunciator
  import annunciator_pkg::*;
#(
  parameter int                          NUM_FLAGS    = 8,
  parameter int                          ADDR_W       = 10,
  parameter logic [NUM_FLAGS*ADDR_W-1:0] FLAG_POS     = {8{10'd0}},
  parameter int                          HEX_DIGITS   = 2,
  parameter logic [ADDR_W-1:0]           HEX_POS      = 10'd199,
  parameter logic [ADDR_W-1:0]           RESTART_ADDR = 10'd4,
  parameter logic [7:0]                  ON_CHAR      = "1",
  parameter logic [7:0]                  OFF_CHAR     = "0",
  // Template image: byte k of the ROM sits at bits [8*k +: 8].
  parameter logic [8*(2**ADDR_W)-1:0]    TEMPLATE     = '0
`ifdef STATUS_ANNUNCIATOR_FRAME_COUNT_EN
  , parameter logic [ADDR_W-1:0]         FRAME_POS    = 10'd230
`endif
) (
  input  logic                    clk48,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [NUM_FLAGS-1:0]    flags,
  input  logic [4*HEX_DIGITS-1:0] hex_val,
  output logic [7:0]              dout,
  output logic                    dout_v,
  input  logic                    dout_rdy,
`ifdef STATUS_ANNUNCIATOR_FRAME_COUNT_EN
  output logic [15:0]             frame_cnt,
`endif
  output logic                    frame_start
);

  ann_state_t             state, state_nx;
  logic [ADDR_W-1:0]      ptr;
  logic                   first_frame;
  logic [NUM_FLAGS-1:0]   snap_flags;
  logic [4*HEX_DIGITS-1:0] snap_hex;
  logic [7:0]             rom_q, ch;
  logic                   take_snap, load_out, accept, end_frame;

  always_ff @(posedge clk48)
    rom_q <= TEMPLATE[{ptr, 3'b000} +: 8];

  ann_char_mux #(
    .NUM_FLAGS (NUM_FLAGS),
    .ADDR_W    (ADDR_W),
    .FLAG_POS  (FLAG_POS),
    .HEX_DIGITS(HEX_DIGITS),
    .HEX_POS   (HEX_POS),
    .ON_CHAR   (ON_CHAR),
    .OFF_CHAR  (OFF_CHAR)
`ifdef STATUS_ANNUNCIATOR_FRAME_COUNT_EN
    , .FRAME_POS(FRAME_POS)
`endif
  ) u_mux (
    .ptr       (ptr),
    .snap_flags(snap_flags),
    .snap_hex  (snap_hex),
`ifdef STATUS_ANNUNCIATOR_FRAME_COUNT_EN
    .snap_cnt  (frame_cnt),
`endif
    .rom_byte  (rom_q),
    .ch        (ch)
  );

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    take_snap = 1'b0;
    load_out  = 1'b0;
    accept    = 1'b0;
    end_frame = 1'b0;
    case (state)
      IDLE:  if (enable) begin
               take_snap = 1'b1;
               state_nx  = FETCH;
             end
      FETCH: state_nx = WAIT;
      WAIT:  if (rom_q == END_MARK) begin
               end_frame = 1'b1;
               state_nx  = IDLE;
             end else begin
               load_out  = 1'b1;
               state_nx  = OUT;
             end
      OUT:   if (dout_rdy) begin
               accept    = 1'b1;
               state_nx  = FETCH;
             end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      ptr         <= '0;
      first_frame <= 1'b1;
      snap_flags  <= '0;
      snap_hex    <= '0;
      dout        <= 8'h00;
      dout_v      <= 1'b0;
      frame_start <= 1'b0;
`ifdef STATUS_ANNUNCIATOR_FRAME_COUNT_EN
      frame_cnt   <= 16'h0000;
`endif
    end else begin
      frame_start <= take_snap;
      if (take_snap) begin
        snap_flags <= flags;
        snap_hex   <= hex_val;
        ptr        <= first_frame ? '0 : RESTART_ADDR;
`ifdef STATUS_ANNUNCIATOR_FRAME_COUNT_EN
        frame_cnt  <= frame_cnt + 16'd1;
`endif
      end
      if (end_frame) first_frame <= 1'b0;
      if (load_out) begin
        dout   <= ch;
        dout_v <= 1'b1;
      end
      // ptr wraps naturally at the top of the ROM; the template must terminate.
      if (accept) begin
        dout_v <= 1'b0;
        ptr    <= ptr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_status_annunciator.sv
// tb/tb_status_annunciator.sv - scoreboard bench for status_annunciator (honours STATUS_ANNUNCIATOR_FRAME_COUNT_EN)
module tb_status_annunciator;

  localparam int NF = 3;
  localparam int AW = 8;
  localparam int HD = 3;
  localparam logic [NF*AW-1:0] FPOS    = {8'd10, 8'd7, 8'd7};
  localparam logic [AW-1:0]    HPOS    = 8'd10;
  localparam logic [AW-1:0]    RST_A   = 8'd4;
  localparam logic [AW-1:0]    CNT_POS = 8'd14;
  // "\f\033[HF0=x V xxx xxxx\r\n" then end marker at address 20
  localparam logic [8*256-1:0] IMG = {{(236*8){1'b0}}, 8'h0A, 8'h0D, "xxxx", " ", "xxx", "V", " ",
                                      "x", "=0F", "H[", 8'h1B, 8'h0C};

  logic            clk48 = 1'b0;
  logic            rst_n = 1'b0;
  logic            enable = 1'b0;
  logic            dout_rdy = 1'b1;
  logic [NF-1:0]   flags = '0;
  logic [4*HD-1:0] hex_val = '0;
  logic [7:0]      dout;
  logic            dout_v, frame_start;
`ifdef STATUS_ANNUNCIATOR_FRAME_COUNT_EN
  logic [15:0]     frame_cnt;
`endif

  int checks = 0, errors = 0, fs_seen = 0, exp_cnt = 0;
  logic [7:0] exp_q[$];
  logic [8*256-1:0] img_v = IMG;
  string hexs = "0123456789ABCDEF";

  always #10 clk48 = ~clk48;

  status_annunciator #(
    .NUM_FLAGS(NF), .ADDR_W(AW), .FLAG_POS(FPOS), .HEX_DIGITS(HD), .HEX_POS(HPOS),
    .RESTART_ADDR(RST_A), .ON_CHAR("1"), .OFF_CHAR("0"), .TEMPLATE(IMG)
`ifdef STATUS_ANNUNCIATOR_FRAME_COUNT_EN
    , .FRAME_POS(CNT_POS)
`endif
  ) dut (
    .clk48(clk48), .rst_n(rst_n), .enable(enable), .flags(flags), .hex_val(hex_val),
    .dout(dout), .dout_v(dout_v), .dout_rdy(dout_rdy),
`ifdef STATUS_ANNUNCIATOR_FRAME_COUNT_EN
    .frame_cnt(frame_cnt),
`endif
    .frame_start(frame_start)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_byte(input int a, input logic [NF-1:0] f,
                                            input logic [4*HD-1:0] h, input int cnt);
    logic [7:0]  b;
    logic [15:0] c16;
    c16 = 16'(cnt);
    b = img_v[8*a +: 8];
`ifdef STATUS_ANNUNCIATOR_FRAME_COUNT_EN
    if (a >= 14 && a <= 17) b = hexs[int'(c16[4*(17-a) +: 4])];
`endif
    if (a >= 10 && a <= 12) b = hexs[int'(h[4*(12-a) +: 4])];
    if (a == 7)  b = f[0] ? "1" : "0";   // flag1 also maps here but loses to flag0
    if (a == 10) b = f[2] ? "1" : "0";   // flag2 beats hex digit 0
    return b;
  endfunction

  task automatic push_frame(input bit first, input logic [NF-1:0] f, input logic [4*HD-1:0] h);
    int a;
    exp_cnt++;
    a = first ? 0 : 4;
    while (img_v[8*a +: 8] != 8'h00) begin
      exp_q.push_back(model_byte(a, f, h, exp_cnt));
      a++;
    end
  endtask

  task automatic wait_fs(input int target);
    int n;
    n = 0;
    while (fs_seen < target && n < 3000) begin
      @(negedge clk48);
      n++;
    end
    check("frame_start_count", fs_seen, target);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk48);
      n++;
    end
    check("drain", exp_q.size(), 0);
    repeat (10) @(negedge clk48);
  endtask

  task automatic find_valid();
    int n;
    n = 0;
    do begin
      @(posedge clk48);
      #1;
      n++;
    end while (!dout_v && n < 50);
    check("find_valid", dout_v, 1'b1);
  endtask

  always @(negedge clk48) begin
    if (frame_start) fs_seen++;
    if (dout_v) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_byte actual=%02h expected=none", dout);
      end else if (dout_rdy) begin
        check("byte", dout, exp_q.pop_front());
      end else begin
        check("stall_hold", dout, exp_q[0]);
      end
    end
  end

  initial begin
    int lat;
    repeat (3) @(posedge clk48);
    #1;
    check("reset_dout", dout, 8'h00);
    check("reset_dout_v", dout_v, 1'b0);
    check("reset_frame_start", frame_start, 1'b0);
    rst_n = 1'b1;

    // Two back-to-back frames: first from address 0, second from RESTART_ADDR
    flags = 3'b001;
    hex_val = 12'h03C;
    push_frame(1'b1, flags, hex_val);
    push_frame(1'b0, flags, hex_val);
    @(posedge clk48);
    #1 enable = 1'b1;
    @(posedge clk48);
    lat = 0;
    do begin
      @(negedge clk48);
      lat++;
    end while (!dout_v && lat < 10);
    check("first_latency", lat, 3);
    wait_fs(2);
    enable = 1'b0;
    drain();

    // Flag collision (flag0 wins) and flag over hex digit
    flags = 3'b110;
    hex_val = 12'h00A;
    push_frame(1'b0, flags, hex_val);
    enable = 1'b1;
    wait_fs(3);
    enable = 1'b0;
    drain();
`ifdef STATUS_ANNUNCIATOR_FRAME_COUNT_EN
    check("frame_cnt_3", frame_cnt, 16'd3);
`endif

    // Live flag change mid-frame only shows up in the following frame
    flags = 3'b000;
    hex_val = 12'h5F1;
    push_frame(1'b0, 3'b000, hex_val);
    push_frame(1'b0, 3'b001, hex_val);
    enable = 1'b1;
    wait_fs(4);
    repeat (3) @(negedge clk48);
    flags = 3'b001;
    wait_fs(5);
    enable = 1'b0;
    drain();

    // Back-pressure: hold dout_rdy low for 20 cycles on one byte
    hex_val = 12'hB7E;
    push_frame(1'b0, flags, hex_val);
    enable = 1'b1;
    wait_fs(6);
    enable = 1'b0;
    repeat (6) @(posedge clk48);
    find_valid();
    dout_rdy = 1'b0;
    repeat (20) begin
      @(posedge clk48);
      #1;
      check("stall_valid", dout_v, 1'b1);
    end
    dout_rdy = 1'b1;
    drain();

    // Asynchronous reset while a byte is presented, then restart from address 0
    flags = 3'b100;
    hex_val = 12'h123;
    push_frame(1'b0, flags, hex_val);
    enable = 1'b1;
    wait_fs(7);
    enable = 1'b0;
    repeat (5) @(posedge clk48);
    find_valid();
    dout_rdy = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_dout_v", dout_v, 1'b0);
    check("async_reset_dout", dout, 8'h00);
    exp_q.delete();
    exp_cnt = 0;
    repeat (2) @(posedge clk48);
    #1 rst_n = 1'b1;
    dout_rdy = 1'b1;
    flags = 3'b011;
    hex_val = 12'hFED;
    push_frame(1'b1, flags, hex_val);
    enable = 1'b1;
    wait_fs(8);
    enable = 1'b0;
    drain();
`ifdef STATUS_ANNUNCIATOR_FRAME_COUNT_EN
    check("frame_cnt_after_reset", frame_cnt, 16'd1);
`endif
    check("idle_after_frames", dout_v, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

endmodule
